multi_wave_drawer: RTL and testbench

MULTI_WAVE_DRAWER -- requirements
Module: multi_wave_drawer

---
 rtl/multi_wave_drawer.sv | 249 ++++++++++++++++++++++++
 tb/tb_multi_wave_drawer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_wave_drawer.sv
// Purpose: draws CHANNELS waveforms as per-column pixel erase/draw commands, one column per kept sample.
// Latency: first pixel command is valid the cycle after a sample is kept; one command per accepted transfer.
// Backpressure: pix_valid/pix_ready; commands hold while stalled, samples kept while busy are dropped and flag overrun.
module multi_wave_drawer #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2,
    parameter int COLS     = 640,
    parameter int ROWS     = 480,
    parameter int DIV      = 15,
    parameter int SHIFT    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] wave_signal,
    input  logic                      trig_mode,
    input  logic                      pix_ready,
    output logic                      pix_valid,
    output logic                      pen,
    output logic [9:0]                x,
    output logic [8:0]                y,
    output logic                      frame_done,
    output logic                      overrun
);

    // Band height per channel and internal widths
    localparam int BH  = ROWS / CHANNELS;
    localparam int MW  = WIDTH + 12;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        WAIT  = 3'd2,
        ERASE = 3'd3,
        DRAW  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [DW-1:0]  div_cnt;
    logic           keep;
    logic           samp0_neg;
    logic           prev_neg;
    logic [CW-1:0]  col;
    logic [CHW-1:0] ch;
    logic           first_frame;
    logic           busy;
    logic           col_last;
    logic           ch_last;

    // Control strobes from the FSM to the datapath
    logic           latch;
    logic           trig_col0;
    logic           ch_inc;
    logic           col_done;
    logic           mem_we;

    // Freshly computed rows for the current input, and rows latched for the column being drawn
    logic [8:0]     new_y_c [CHANNELS];
    logic [8:0]     new_y   [CHANNELS];

    // Last drawn row per (column, channel); contents are meaningless until drawn once
    logic [8:0]     ymem [COLS][CHANNELS];

    assign keep      = enable && (div_cnt == DW'(DIV - 1));
    assign samp0_neg = wave_signal[WIDTH-1];
    assign busy      = (state == ERASE) || (state == DRAW);
    assign col_last  = (col == CW'(COLS - 1));
    assign ch_last   = (ch == CHW'(CHANNELS - 1));

    // Sample -> row mapping: centre of the band minus the scaled sample, clamped inside the band.
    // The clamp decision is made on the full-width shifted sample; only in the unclamped case
    // is the row formed, and then the result lies inside the band so 9-bit arithmetic is exact.
    always_comb begin
        logic signed [MW-1:0] ext;
        logic signed [MW-1:0] shf;
        logic [8:0]           lo9;
        logic [8:0]           mid9;
        logic [8:0]           hi9;
        ext  = '0;
        shf  = '0;
        lo9  = '0;
        mid9 = '0;
        hi9  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            new_y_c[c] = '0;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            ext  = MW'($signed(wave_signal[c*WIDTH +: WIDTH]));
            shf  = ext >>> SHIFT;
            lo9  = 9'(c * BH);
            mid9 = 9'(c * BH + BH / 2);
            hi9  = 9'(c * BH + BH - 1);
            if (shf > MW'(BH / 2)) begin
                new_y_c[c] = lo9;
            end else if (shf < MW'(BH / 2 - (BH - 1))) begin
                new_y_c[c] = hi9;
            end else begin
                new_y_c[c] = mid9 - shf[8:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode; trig_mode only matters when leaving IDLE or at column wrap
    always_comb begin
        next_state = state;
        latch      = 1'b0;
        trig_col0  = 1'b0;
        ch_inc     = 1'b0;
        col_done   = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = trig_mode ? ARM : WAIT;
                end
            end
            ARM: begin
                if (!start) begin
                    next_state = IDLE;
                end else if (keep && !samp0_neg && prev_neg) begin
                    latch      = 1'b1;
                    trig_col0  = 1'b1;
                    next_state = first_frame ? DRAW : ERASE;
                end
            end
            WAIT: begin
                if (!start) begin
                    next_state = IDLE;
                end else if (keep) begin
                    latch      = 1'b1;
                    next_state = first_frame ? DRAW : ERASE;
                end
            end
            ERASE: begin
                if (pix_ready) begin
                    next_state = DRAW;
                end
            end
            DRAW: begin
                if (pix_ready) begin
                    mem_we = 1'b1;
                    if (ch_last) begin
                        col_done = 1'b1;
                        if (!start) begin
                            next_state = IDLE;
                        end else if (col_last) begin
                            next_state = trig_mode ? ARM : WAIT;
                        end else begin
                            next_state = WAIT;
                        end
                    end else begin
                        ch_inc     = 1'b1;
                        next_state = first_frame ? DRAW : ERASE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Divider, trigger history, column/channel bookkeeping and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            prev_neg    <= 1'b0;
            col         <= '0;
            ch          <= '0;
            first_frame <= 1'b1;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                new_y[c] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (enable) begin
                div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + DW'(1);
            end
            if (keep) begin
                prev_neg <= samp0_neg;
            end
            if (keep && busy) begin
                overrun <= 1'b1;
            end
            if (latch) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    new_y[c] <= new_y_c[c];
                end
                ch <= '0;
                if (trig_col0) begin
                    col <= '0;
                end
            end
            if (ch_inc) begin
                ch <= ch + CHW'(1);
            end
            if (col_done) begin
                ch <= '0;
                if (col_last) begin
                    col         <= '0;
                    first_frame <= 1'b0;
                    frame_done  <= 1'b1;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Remember what was drawn so the next frame can erase it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ymem[col][ch] <= new_y[ch];
        end
    end

    // Pixel command outputs are decoded from state so reset clears them in the same cycle
    always_comb begin
        pix_valid = busy;
        pen       = (state == DRAW);
        x         = '0;
        y         = '0;
        if (state == ERASE) begin
            x = 10'(col);
            y = ymem[col][ch];
        end else if (state == DRAW) begin
            x = 10'(col);
            y = new_y[ch];
        end
    end

endmodule

// File: tb/tb_multi_wave_drawer.sv
module tb_multi_wave_drawer;

    localparam int WIDTH    = 24;
    localparam int CHANNELS = 2;
    localparam int COLS     = 640;
    localparam int ROWS     = 480;
    localparam int DIV      = 15;
    localparam int SHIFT    = 16;
    localparam int BH       = ROWS / CHANNELS;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        enable    = 1'b0;
    logic        trig_mode = 1'b0;
    logic        pix_ready = 1'b0;
    logic [47:0] wave_signal = '0;
    logic        pix_valid;
    logic        pen;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        frame_done;
    logic        overrun;

    multi_wave_drawer #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .COLS(COLS),
        .ROWS(ROWS), .DIV(DIV), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .enable(enable),
        .wave_signal(wave_signal),
        .trig_mode(trig_mode),
        .pix_ready(pix_ready),
        .pix_valid(pix_valid),
        .pen(pen),
        .x(x),
        .y(y),
        .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pen;
        int   x;
        int   y;
    } pix_t;

    pix_t sb[$];
    pix_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_mem [COLS][CHANNELS];
    int   m_col;
    bit   m_first;
    int   fd_cnt = 0;
    int   fd_x = -1;
    int   last_x = -1;
    int   erase_cnt = 0;
    int   pv_cycles = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference row for a channel: band centre minus sample>>>SHIFT, clamped to the band
    function automatic int exp_y(input int c, input logic signed [23:0] s);
        int v;
        v = c * BH + BH / 2 - (int'(s) >>> SHIFT);
        if (v < c * BH) v = c * BH;
        if (v > c * BH + BH - 1) v = c * BH + BH - 1;
        return v;
    endfunction

    task automatic model_reset();
        m_col   = 0;
        m_first = 1'b1;
    endtask

    // Expected commands for one column: per channel, erase old row (not on first frame) then draw new row
    task automatic push_col(input logic signed [23:0] s0, input logic signed [23:0] s1);
        int ny;
        for (int c = 0; c < CHANNELS; c++) begin
            ny = exp_y(c, (c == 0) ? s0 : s1);
            if (!m_first) sb.push_back('{1'b0, m_col, m_mem[m_col][c]});
            sb.push_back('{1'b1, m_col, ny});
            m_mem[m_col][c] = ny;
        end
        if (m_col == COLS - 1) begin
            m_col   = 0;
            m_first = 1'b0;
        end else begin
            m_col++;
        end
    endtask

    // DIV consecutive enable strobes; the last one keeps the sample
    task automatic strobe(input logic signed [23:0] s0, input logic signed [23:0] s1);
        wave_signal = {s1, s0};
        enable = 1'b1;
        repeat (DIV) @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || pix_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check_val("drain_timeout", n, 0);
    endtask

    task automatic send_col(input logic signed [23:0] s0, input logic signed [23:0] s1);
        push_col(s0, s1);
        strobe(s0, s1);
        wait_drain();
    endtask

    // Output monitor: every accepted transfer is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (reset && pix_valid) pv_cycles++;
        if (reset && pix_valid && pix_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_pix_x", x, -1);
            end else begin
                mon_e = sb.pop_front();
                check_val("pen", pen, mon_e.pen);
                check_val("x", x, mon_e.x);
                check_val("y", y, mon_e.y);
            end
            if (!pen) erase_cnt++;
            last_x = x;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_x = last_x;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        logic signed [23:0] r0;
        logic signed [23:0] r1;
        pix_t e0;
        int   er0;
        int   pv0;

        model_reset();
        #1 reset = 1'b0;
        #2;
        check_val("rst_pix_valid", pix_valid, 0);
        check_val("rst_pen", pen, 0);
        check_val("rst_x", x, 0);
        check_val("rst_y", y, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // First column, free-run: draws only, rows 119 / 361
        trig_mode = 1'b0;
        start     = 1'b1;
        pix_ready = 1'b1;
        er0 = erase_cnt;
        send_col(24'sh010000, 24'shFF0000);
        check_val("first_col_no_erase", erase_cnt - er0, 0);

        // Clamp at both band edges
        send_col(24'sh7FFFFF, 24'sh800000);

        // Fill the rest of the frame
        for (int c = 2; c < COLS - 1; c++) begin
            r0 = 24'($urandom());
            r1 = 24'($urandom());
            send_col(r0, r1);
        end
        check_val("frame_done_early", fd_cnt, 0);
        send_col(24'sh030000, 24'shFD0000);
        repeat (2) @(posedge clk);
        #1;
        check_val("frame_done_count", fd_cnt, 1);
        check_val("frame_done_col", fd_x, COLS - 1);

        // Second frame column 0: erase stored rows, then draw
        er0 = erase_cnt;
        send_col(24'sh020000, 24'sh000000);
        check_val("frame2_erase_count", erase_cnt - er0, CHANNELS);

        // Stall with a kept sample arriving while busy
        check_val("overrun_pre", overrun, 0);
        pix_ready = 1'b0;
        push_col(24'sh100000, 24'shF00000);
        strobe(24'sh100000, 24'shF00000);
        e0 = sb[0];
        fork
            strobe(24'sh050000, 24'sh050000);
            begin
                repeat (14) begin
                    @(negedge clk);
                    check_val("stall_valid", pix_valid, 1);
                    check_val("stall_pen", pen, e0.pen);
                    check_val("stall_x", x, e0.x);
                    check_val("stall_y", y, e0.y);
                end
            end
        join
        check_val("overrun_set", overrun, 1);
        check_val("stall_nothing_taken", sb.size(), 2 * CHANNELS);
        pix_ready = 1'b1;
        wait_drain();
        send_col(24'sh000000, 24'sh000000);
        check_val("overrun_sticky", overrun, 1);

        // Reset during DRAW
        reset = 1'b0;
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send_col(24'sh001000, 24'sh001000);
        pix_ready = 1'b0;
        push_col(24'sh200000, 24'sh200000);
        strobe(24'sh200000, 24'sh200000);
        check_val("mid_draw_valid", pix_valid, 1);
        check_val("mid_draw_pen", pen, 1);
        check_val("mid_draw_x", x, 1);
        check_val("mid_draw_y", y, exp_y(0, 24'sh200000));
        #2 reset = 1'b0;
        #1;
        check_val("arst_pix_valid", pix_valid, 0);
        check_val("arst_pen", pen, 0);
        check_val("arst_x", x, 0);
        check_val("arst_y", y, 0);
        check_val("arst_overrun", overrun, 0);
        sb.delete();
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        pix_ready = 1'b1;
        er0 = erase_cnt;
        send_col(24'sh040000, 24'sh040000);
        check_val("post_reset_no_erase", erase_cnt - er0, 0);

        // Trigger mode: -5, -1 discarded, +3 becomes column 0
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        trig_mode = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        pv0 = pv_cycles;
        strobe(-24'sd5, 24'sd0);
        repeat (3) @(posedge clk);
        #1;
        strobe(-24'sd1, 24'sd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("arm_no_pixels", pv_cycles - pv0, 0);
        m_col = 0;
        send_col(24'sd3, 24'sh050000);
        send_col(24'sh010000, 24'sh010000);

        check_val("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
